dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port DataMemory (clk, WE, A, WD, RD) between two requesters: port 0 (CPU load/store stage) and port 1 (DMA/debug loader).
- Grants at most one access per cycle, drives the memory's WE/A/WD, and returns registered read data to the winning requester one cycle later.
- Supports a lock for back-to-back bursts by one requester.
- Sits between the requesters and the `DataMemory` instance in the top level.

Parameters:
- AW, 32, address width (matches DataMemory A)
- DW, 32, data width (matches DataMemory WD/RD)

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  port 0 access request; held until m0_gnt
- m0_we  in  1  port 0 write(1)/read(0)
- m0_lock  in  1  port 0 requests exclusive ownership after this grant
- m0_addr  in  AW  port 0 byte address
- m0_wdata  in  DW  port 0 write data
- m0_gnt  out  1  port 0 access performed this cycle
- m0_rvalid  out  1  port 0 read data valid
- m0_rdata  out  DW  port 0 read data
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as port 0, for port 1
- mem_we  out  1  to DataMemory WE
- mem_a  out  AW  to DataMemory A
- mem_wd  out  DW  to DataMemory WD
- mem_rd  in  DW  from DataMemory RD (combinational read)

Behaviour:
- Clocking and reset:
  - Single clock `clk`.
  - `reset` is synchronous and active-high.
  - While reset=1: m0_gnt=m1_gnt=0, mem_we=0, mem_a=0, mem_wd=0, mX_rvalid=0, mX_rdata=0, state=IDLE, last_grant=1 (port 0 wins the first contest).
- Grant is combinational in the request cycle:
  - The winner's addr/wdata/we are muxed onto mem_a/mem_wd/mem_we.
  - With no grant: mem_we=0, mem_a=0, mem_wd=0.
  - mem_we = gnt & we; never high without a grant.
- Write: commits at the posedge ending the grant cycle. No response pulse.
- Read:
  - mem_rd is captured at the posedge ending the grant cycle.
  - In the next cycle, mX_rvalid=1 for exactly 1 cycle and mX_rdata holds the data (latency 1).
  - mX_rdata holds its value until the next read for that port.
- Requester rules:
  - req/we/addr/wdata must stay stable until gnt.
  - A new request may be presented in the cycle after gnt, or in the same cycle that rvalid is high.
- FSM states: IDLE, LOCK0, LOCK1.
  - IDLE: arbitrate (see Optional Feature).
    - Winner k with mk_lock=1 goes to LOCKk.
    - Otherwise stay in IDLE.
  - LOCKk: only port k may be granted; the other port waits with gnt=0.
    - Grant to k with mk_lock=0 returns to IDLE.
    - mk_req=0 for a cycle returns to IDLE in the next cycle (release; no grant that cycle to the other port).
    - Grant to k with mk_lock=1 stays in LOCKk.
- last_grant is updated to the granted port index on every grant.
- Simultaneous events:
  - Both ports request in IDLE: exactly one gnt; the other is served in the next cycle, provided the winner did not lock.
  - mX_rvalid for one port can coincide with a gnt to either port.
- Reset mid-operation (reset in the cycle after a read grant): rvalid is suppressed (stays 0), the FSM returns to IDLE, and no write occurs during reset.
- Addresses are passed through unmodified; there is no alignment check.

Optional Feature:
- Macro `DMEM_ARB_ROUND_ROBIN_EN`.
  - Defined: in IDLE with both requesting, the winner is the port ≠ last_grant (alternates).
  - Undefined: fixed priority; port 0 always wins in IDLE, and last_grant is still maintained but unused.
- Lock behaviour is identical in both builds.

Decomposition:
- Shared package/include `dmem_arb_pkg`:
  - state encodings ST_IDLE=2'd0, ST_LOCK0=2'd1, ST_LOCK1=2'd2
  - port indices P0=1'b0, P1=1'b1
  - RD_LATENCY=1
- One natural sub-module, `dmem_arb_pick`: purely combinational winner selection from (req0, req1, state, last_grant), containing the `DMEM_ARB_ROUND_ROBIN_EN` choice.
- The top module holds the FSM, last_grant, rvalid/rdata registers and the memory mux.

Test Plan:
- Reset, then m0 write addr=64 data=45, next cycle m0 read addr=64 -> m0_gnt each cycle; m0_rvalid=1 with m0_rdata=45 one cycle after the read grant; m1_rvalid stays 0.
- m0 write 64/45 and m1 write 128/100 asserted in the same cycle -> m0 granted first, m1 in the next cycle; subsequent reads return 45 at 64 and 100 at 128.
- Both ports read continuously for 6 cycles -> with `DMEM_ARB_ROUND_ROBIN_EN`, grants alternate 0,1,0,1,0,1; without it, m0 is granted all 6 and m1_gnt=0.
- m1 issues 3 lock=1 reads then one lock=0 read while m0 requests throughout -> m0_gnt=0 for those 4 cycles and is granted in the 5th.
- reset pulsed in the cycle after an m0 read grant at addr 128 -> m0_rvalid=0, FSM in IDLE, mem_we=0; the next m0 read at 128 returns 100.
- m1 in LOCK1 drops m1_req for one cycle -> no grant in that cycle; m0 is granted in the following cycle.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared encodings for the data-memory arbiter.
// Arbitration mode is chosen by DMEM_ARB_ROUND_ROBIN_EN in dmem_arb_pick.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOCK0 = 2'd1,
      ST_LOCK1 = 2'd2
   } state_t;

   localparam logic P0 = 1'b0;
   localparam logic P1 = 1'b1;

   localparam int RD_LATENCY = 1;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner selection for the two memory ports.
// Define DMEM_ARB_ROUND_ROBIN_EN to alternate between ports on contention in
// IDLE; otherwise port 0 has fixed priority. Locked states ignore the mode.
module dmem_arb_pick
   import dmem_arb_pkg::*;
(
   input  logic   req0,
   input  logic   req1,
   input  state_t state,
   input  logic   last_grant,
   output logic   gnt0,
   output logic   gnt1
);

`ifndef DMEM_ARB_ROUND_ROBIN_EN
   // Fixed priority keeps last_grant in the interface but never looks at it.
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

   // Pick at most one winner: the lock owner only, or arbitrate when idle.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      case (state)
         ST_LOCK0: gnt0 = req0;
         ST_LOCK1: gnt1 = req1;
         default: begin
            if (req0 && req1) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
               if (last_grant == P0) begin
                  gnt1 = 1'b1;
               end else begin
                  gnt0 = 1'b1;
               end
`else
               gnt0 = 1'b1;
`endif
            end else begin
               gnt0 = req0;
               gnt1 = req1;
            end
         end
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port DataMemory between the CPU (port 0)
// and the DMA/debug loader (port 1). Grants are combinational, read data
// returns one cycle after the grant, and a requester may lock the memory for
// back-to-back bursts. Build option: DMEM_ARB_ROUND_ROBIN_EN (see dmem_arb_pick).
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic          m0_lock,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic          m1_lock,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_a,
   output logic [DW-1:0] mem_wd,
   input  logic [DW-1:0] mem_rd
);

   state_t        state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic          rvalid0_q, rvalid0_d;
   logic          rvalid1_q, rvalid1_d;
   logic [DW-1:0] rdata0_q, rdata0_d;
   logic [DW-1:0] rdata1_q, rdata1_d;
   logic          pick0, pick1;
   logic          gnt0, gnt1;

   dmem_arb_pick u_pick (
      .req0       (m0_req),
      .req1       (m1_req),
      .state      (state_q),
      .last_grant (last_grant_q),
      .gnt0       (pick0),
      .gnt1       (pick1)
   );

   // Reset blocks every grant so nothing reaches the memory while it is held.
   assign gnt0 = pick0 & ~reset;
   assign gnt1 = pick1 & ~reset;

   assign m0_gnt    = gnt0;
   assign m1_gnt    = gnt1;
   assign m0_rvalid = rvalid0_q & ~reset;
   assign m1_rvalid = rvalid1_q & ~reset;
   assign m0_rdata  = reset ? '0 : rdata0_q;
   assign m1_rdata  = reset ? '0 : rdata1_q;

   // Steer the winning port onto the memory; an idle bus is driven to zero.
   always_comb begin
      mem_we = 1'b0;
      mem_a  = '0;
      mem_wd = '0;
      if (gnt0) begin
         mem_we = m0_we;
         mem_a  = m0_addr;
         mem_wd = m0_wdata;
      end else if (gnt1) begin
         mem_we = m1_we;
         mem_a  = m1_addr;
         mem_wd = m1_wdata;
      end
   end

   // Next-state for the lock FSM, grant history and the read-return registers.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      rvalid0_d    = gnt0 & ~m0_we;
      rvalid1_d    = gnt1 & ~m1_we;
      rdata0_d     = (gnt0 && !m0_we) ? mem_rd : rdata0_q;
      rdata1_d     = (gnt1 && !m1_we) ? mem_rd : rdata1_q;

      if (gnt0) begin
         last_grant_d = P0;
      end else if (gnt1) begin
         last_grant_d = P1;
      end

      case (state_q)
         ST_IDLE: begin
            if (gnt0 && m0_lock) begin
               state_d = ST_LOCK0;
            end else if (gnt1 && m1_lock) begin
               state_d = ST_LOCK1;
            end
         end
         ST_LOCK0: begin
            if (!m0_req || (gnt0 && !m0_lock)) begin
               state_d = ST_IDLE;
            end
         end
         ST_LOCK1: begin
            if (!m1_req || (gnt1 && !m1_lock)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Register all arbiter state; reset favours port 0 in the first contest.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= P1;
         rvalid0_q    <= 1'b0;
         rvalid1_q    <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         rvalid0_q    <= rvalid0_d;
         rvalid1_q    <= rvalid1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter. Grants and memory-bus
// values are checked in the grant cycle; expected read data is queued per
// port and popped by an independent monitor when the DUT raises rvalid.
// Honours DMEM_ARB_ROUND_ROBIN_EN for the contention pattern.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        m0_req, m0_we, m0_lock;
   logic [31:0] m0_addr, m0_wdata;
   logic        m0_gnt, m0_rvalid;
   logic [31:0] m0_rdata;
   logic        m1_req, m1_we, m1_lock;
   logic [31:0] m1_addr, m1_wdata;
   logic        m1_gnt, m1_rvalid;
   logic [31:0] m1_rdata;
   logic        mem_we;
   logic [31:0] mem_a, mem_wd, mem_rd;

   logic [31:0] mem [0:255];

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic exp_g0;

   dmem_arbiter #(.AW(32), .DW(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .m0_req    (m0_req),
      .m0_we     (m0_we),
      .m0_lock   (m0_lock),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_gnt    (m0_gnt),
      .m0_rvalid (m0_rvalid),
      .m0_rdata  (m0_rdata),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_lock   (m1_lock),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_gnt    (m1_gnt),
      .m1_rvalid (m1_rvalid),
      .m1_rdata  (m1_rdata),
      .mem_we    (mem_we),
      .mem_a     (mem_a),
      .mem_wd    (mem_wd),
      .mem_rd    (mem_rd)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Cycle counter used to check that read data arrives exactly one cycle late.
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural DataMemory: word-indexed, synchronous write, combinational read.
   always @(posedge clk) begin
      if (mem_we) mem[mem_a[9:2]] <= mem_wd;
   end
   assign mem_rd = mem[mem_a[9:2]];

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs just after the edge, then settle before checks.
   task automatic applyStimulus(input logic rst,
                                input logic r0, input logic w0, input logic l0,
                                input logic [31:0] a0, input logic [31:0] d0,
                                input logic r1, input logic w1, input logic l1,
                                input logic [31:0] a1, input logic [31:0] d1);
      @(posedge clk);
      #1;
      reset    = rst;
      m0_req   = r0;
      m0_we    = w0;
      m0_lock  = l0;
      m0_addr  = a0;
      m0_wdata = d0;
      m1_req   = r1;
      m1_we    = w1;
      m1_lock  = l1;
      m1_addr  = a1;
      m1_wdata = d1;
      #2;
   endtask

   task automatic idleCycle(input logic rst);
      applyStimulus(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic checkGrant(input string tag, input logic g0, input logic g1);
      checkOutput({tag, "_m0_gnt"}, {31'b0, m0_gnt}, {31'b0, g0});
      checkOutput({tag, "_m1_gnt"}, {31'b0, m1_gnt}, {31'b0, g1});
   endtask

   // Queue the read data a granted read must return on the following cycle.
   task automatic expectRead(input int port, input logic [31:0] data);
      exp_t e;
      e.data = data;
      e.due  = cyc + 1;
      if (port == 0) q0.push_back(e);
      else           q1.push_back(e);
   endtask

   // Monitor: on each falling edge match any rvalid against the scoreboard,
   // and flag any queued read whose return cycle passed without rvalid.
   always @(negedge clk) begin
      if (m0_rvalid) begin
         if (q0.size() == 0) begin
            checkOutput("m0_rvalid_unexpected", {31'b0, m0_rvalid}, 32'd0);
         end else begin
            e0 = q0.pop_front();
            checkOutput("m0_rdata", m0_rdata, e0.data);
            checkOutput("m0_rlatency", cyc, e0.due);
         end
      end else if (q0.size() > 0 && q0[0].due <= cyc) begin
         e0 = q0.pop_front();
         checkOutput("m0_rvalid_missing", {31'b0, m0_rvalid}, 32'd1);
      end
      if (m1_rvalid) begin
         if (q1.size() == 0) begin
            checkOutput("m1_rvalid_unexpected", {31'b0, m1_rvalid}, 32'd0);
         end else begin
            e1 = q1.pop_front();
            checkOutput("m1_rdata", m1_rdata, e1.data);
            checkOutput("m1_rlatency", cyc, e1.due);
         end
      end else if (q1.size() > 0 && q1[0].due <= cyc) begin
         e1 = q1.pop_front();
         checkOutput("m1_rvalid_missing", {31'b0, m1_rvalid}, 32'd1);
      end
   end

   // Directed scenario sequence.
   initial begin
      m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;

      // Reset holds everything quiet even with both ports requesting.
      idleCycle(1);
      applyStimulus(1, 1, 1, 0, 64, 45, 1, 1, 0, 128, 100);
      checkGrant("rst", 0, 0);
      checkOutput("rst_mem_we", {31'b0, mem_we}, 0);
      checkOutput("rst_mem_a", mem_a, 0);
      checkOutput("rst_mem_wd", mem_wd, 0);
      checkOutput("rst_m0_rvalid", {31'b0, m0_rvalid}, 0);
      checkOutput("rst_m1_rvalid", {31'b0, m1_rvalid}, 0);
      checkOutput("rst_m0_rdata", m0_rdata, 0);

      // Port 0 write then read back.
      applyStimulus(0, 1, 1, 0, 64, 45, 0, 0, 0, 0, 0);
      checkGrant("t1w", 1, 0);
      checkOutput("t1w_mem_we", {31'b0, mem_we}, 1);
      checkOutput("t1w_mem_a", mem_a, 64);
      checkOutput("t1w_mem_wd", mem_wd, 45);
      applyStimulus(0, 1, 0, 0, 64, 0, 0, 0, 0, 0, 0);
      checkGrant("t1r", 1, 0);
      checkOutput("t1r_mem_we", {31'b0, mem_we}, 0);
      expectRead(0, 45);
      idleCycle(0);
      checkGrant("t1i", 0, 0);
      checkOutput("t1i_mem_a", mem_a, 0);

      // Simultaneous writes: port 0 first, port 1 next cycle; read both back.
      idleCycle(1);
      applyStimulus(0, 1, 1, 0, 64, 45, 1, 1, 0, 128, 100);
      checkGrant("t2w0", 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 128, 100);
      checkGrant("t2w1", 0, 1);
      checkOutput("t2w1_mem_we", {31'b0, mem_we}, 1);
      checkOutput("t2w1_mem_a", mem_a, 128);
      checkOutput("t2w1_mem_wd", mem_wd, 100);
      applyStimulus(0, 1, 0, 0, 64, 0, 1, 0, 0, 128, 0);
      checkGrant("t2r0", 1, 0);
      expectRead(0, 45);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 128, 0);
      checkGrant("t2r1", 0, 1);
      expectRead(1, 100);
      idleCycle(0);

      // Both ports read continuously for six cycles.
      idleCycle(1);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, 1, 0, 0, 64, 0, 1, 0, 0, 128, 0);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
         exp_g0 = (i % 2 == 0);
`else
         exp_g0 = 1'b1;
`endif
         checkGrant($sformatf("t3c%0d", i), exp_g0, ~exp_g0);
         if (exp_g0) expectRead(0, 45);
         else        expectRead(1, 100);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 128, 0);
      checkGrant("t3tail", 0, 1);
      expectRead(1, 100);
      idleCycle(0);

      // Port 1 locked burst holds port 0 off until the unlocked read.
      idleCycle(1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 128, 0);
      checkGrant("t4l0", 0, 1);
      expectRead(1, 100);
      for (int i = 1; i < 3; i++) begin
         applyStimulus(0, 1, 0, 0, 64, 0, 1, 0, 1, 128, 0);
         checkGrant($sformatf("t4l%0d", i), 0, 1);
         expectRead(1, 100);
      end
      applyStimulus(0, 1, 0, 0, 64, 0, 1, 0, 0, 128, 0);
      checkGrant("t4u", 0, 1);
      expectRead(1, 100);
      applyStimulus(0, 1, 0, 0, 64, 0, 0, 0, 0, 0, 0);
      checkGrant("t4m0", 1, 0);
      expectRead(0, 45);
      idleCycle(0);

      // Reset right after a read grant: no rvalid, no write during reset.
      idleCycle(1);
      applyStimulus(0, 1, 0, 0, 128, 0, 0, 0, 0, 0, 0);
      checkGrant("t5r", 1, 0);
      applyStimulus(1, 1, 1, 0, 128, 999, 0, 0, 0, 0, 0);
      checkGrant("t5rst", 0, 0);
      checkOutput("t5rst_mem_we", {31'b0, mem_we}, 0);
      checkOutput("t5rst_m0_rvalid", {31'b0, m0_rvalid}, 0);
      applyStimulus(0, 1, 0, 0, 128, 0, 0, 0, 0, 0, 0);
      checkGrant("t5r2", 1, 0);
      expectRead(0, 100);
      idleCycle(0);

      // Lock owner drops its request: dead cycle, then port 0 is served.
      idleCycle(1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 128, 0);
      checkGrant("t6l", 0, 1);
      expectRead(1, 100);
      applyStimulus(0, 1, 0, 0, 64, 0, 0, 0, 0, 0, 0);
      checkGrant("t6rel", 0, 0);
      applyStimulus(0, 1, 0, 0, 64, 0, 0, 0, 0, 0, 0);
      checkGrant("t6m0", 1, 0);
      expectRead(0, 45);
      idleCycle(0);
      idleCycle(0);
      idleCycle(0);

      checkOutput("scoreboard_empty", q0.size() + q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
